// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
//   Shared definitions for the sequential divider (and its multiplier sibling's
//   control logic): FSM state encoding, counter sizing and a magnitude helper.
//
//   Contents
//     div_state_e   : IDLE / ITER / FIX / DONE
//     DIV_N_DEFAULT : default operand width
//     CNT_W         : iteration counter width for the default operand width
//     cnt_width()   : iteration counter width for an arbitrary operand width
//     abs_n()       : magnitude of an n-bit two's complement value (n <= 32)
// -----------------------------------------------------------------------------
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    localparam int DIV_N_DEFAULT = 4;
    localparam int CNT_W         = $clog2(DIV_N_DEFAULT);

    // Counter must hold N-1, so $clog2(N) bits suffice for N >= 2.
    function automatic int cnt_width(input int n);
        return $clog2(n);
    endfunction

    // v carries an n-bit two's complement value zero-extended to 32 bits.
    // The low n bits of the result are the unsigned magnitude; the most
    // negative value maps to 2^(n-1), which still fits in n unsigned bits.
    function automatic logic [31:0] abs_n(input logic [31:0] v, input int n);
        logic neg;
        neg = v[5'(n - 1)];
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/nonrestoring_div_step.sv
// -----------------------------------------------------------------------------
// nonrestoring_div_step
//   One combinational iteration of non-restoring division on magnitudes.
//   The partial remainder A and the quotient/dividend register Q shift left
//   together; A then adds or subtracts the divisor depending on the sign A had
//   before the shift, and the new quotient bit is the inverted sign of A.
//
//   Ports
//     a_in  [N:0]   partial remainder, signed
//     q_in  [N-1:0] quotient bits so far / remaining dividend bits
//     v_in  [N:0]   divisor magnitude, zero-extended
//     a_out [N:0]   partial remainder after this step
//     q_out [N-1:0] quotient register after this step
// -----------------------------------------------------------------------------
module nonrestoring_div_step #(
    parameter int N = 4
) (
    input  logic [N:0]   a_in,
    input  logic [N-1:0] q_in,
    input  logic [N:0]   v_in,
    output logic [N:0]   a_out,
    output logic [N-1:0] q_out
);

    logic [N:0] a_sh;

    always_comb begin
        // Next dividend bit enters A from the top of Q.
        a_sh = {a_in[N-1:0], q_in[N-1]};
        if (a_in[N]) begin
            a_out = a_sh + v_in;
        end else begin
            a_out = a_sh - v_in;
        end
        q_out = {q_in[N-2:0], ~a_out[N]};
    end

endmodule

// File: rtl/nonrestoring_divider.sv
// -----------------------------------------------------------------------------
// nonrestoring_divider
//   Sequential signed integer divider. Operand magnitudes are divided with the
//   non-restoring algorithm, one quotient bit per clock, then a single FIX
//   cycle restores a negative remainder and applies the latched signs.
//   Quotient truncates toward zero; remainder takes the dividend's sign.
//
//   Optional feature macro: DIV_ZERO_DETECT_EN
//     defined   : a zero divisor on the accept edge jumps straight to DONE with
//                 div_zero=1, quotient=all ones, remainder=dividend.
//     undefined : div_zero is tied low and a zero divisor runs the full
//                 sequence (quotient magnitude all ones, remainder=dividend).
//
//   Handshake: start is accepted on a rising edge only while the FSM is in IDLE
//   or DONE (busy=0); operands are sampled on that same edge. While busy=1,
//   start and operands are ignored. valid pulses for the single DONE cycle,
//   N+2 cycles after the accept cycle (1 cycle for a trapped zero divisor).
//   Holding start high through DONE re-accepts immediately.
//
//   Ports
//     clk        in   rising-edge clock
//     reset      in   synchronous active-high reset
//     dividend   in   [N-1:0] signed dividend
//     divisor    in   [N-1:0] signed divisor
//     start      in   operation request
//     quotient   out  [N-1:0] signed quotient
//     remainder  out  [N-1:0] signed remainder
//     valid      out  result-updated pulse
//     busy       out  high in ITER and FIX
//     div_zero   out  divide-by-zero flag
//     dbg_state  out  current FSM state
// -----------------------------------------------------------------------------
module nonrestoring_divider
    import div_pkg::*;
#(
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     dividend,
    input  logic [N-1:0]     divisor,
    input  logic             start,
    output logic [N-1:0]     quotient,
    output logic [N-1:0]     remainder,
    output logic             valid,
    output logic             busy,
    output logic             div_zero,
    output div_state_e       dbg_state
);

    localparam int CNT_BITS = cnt_width(N);

    div_state_e          state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [N:0]          a_q, a_d;
    logic [N-1:0]        qreg_q, qreg_d;
    logic [N:0]          vreg_q, vreg_d;
    logic                neg_quot_q, neg_quot_d;
    logic                neg_rem_q, neg_rem_d;
    logic [N-1:0]        quotient_q, quotient_d;
    logic [N-1:0]        remainder_q, remainder_d;
`ifdef DIV_ZERO_DETECT_EN
    logic                div_zero_q, div_zero_d;
`endif

    logic                accept;
    logic                zero_trap;
    logic [N-1:0]        dd_mag;
    logic [N-1:0]        dv_mag;
    logic [N:0]          step_a;
    logic [N-1:0]        step_q;
    logic [N-1:0]        rem_mag;

    assign accept = start && ((state_q == IDLE) || (state_q == DONE));

`ifdef DIV_ZERO_DETECT_EN
    assign zero_trap = (divisor == '0);
`else
    assign zero_trap = 1'b0;
`endif

    assign dd_mag = N'(abs_n(32'(dividend), N));
    assign dv_mag = N'(abs_n(32'(divisor), N));

    nonrestoring_div_step #(
        .N (N)
    ) u_step (
        .a_in  (a_q),
        .q_in  (qreg_q),
        .v_in  (vreg_q),
        .a_out (step_a),
        .q_out (step_q)
    );

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = zero_trap ? DONE : ITER;
                end
            end
            ITER: begin
                if (cnt_q == '0) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = DONE;
            end
            DONE: begin
                if (start) begin
                    state_d = zero_trap ? DONE : ITER;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        valid     = (state_q == DONE);
        busy      = (state_q == ITER) || (state_q == FIX);
        dbg_state = state_q;
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
`ifdef DIV_ZERO_DETECT_EN
    assign div_zero  = div_zero_q;
`else
    assign div_zero  = 1'b0;
`endif

    // ------------------------------------------------------------- datapath
    // Final restore: a negative partial remainder is one divisor short.
    assign rem_mag = a_q[N] ? (a_q[N-1:0] + vreg_q[N-1:0]) : a_q[N-1:0];

    always_comb begin
        cnt_d       = cnt_q;
        a_d         = a_q;
        qreg_d      = qreg_q;
        vreg_d      = vreg_q;
        neg_quot_d  = neg_quot_q;
        neg_rem_d   = neg_rem_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
`ifdef DIV_ZERO_DETECT_EN
        div_zero_d  = div_zero_q;
`endif

        if (accept) begin
            neg_quot_d = dividend[N-1] ^ divisor[N-1];
            neg_rem_d  = dividend[N-1];
            qreg_d     = dd_mag;
            vreg_d     = {1'b0, dv_mag};
            a_d        = '0;
            cnt_d      = CNT_BITS'(N - 1);
`ifdef DIV_ZERO_DETECT_EN
            div_zero_d = 1'b0;
            if (zero_trap) begin
                quotient_d  = '1;
                remainder_d = dividend;
                div_zero_d  = 1'b1;
            end
`endif
        end else if (state_q == ITER) begin
            a_d    = step_a;
            qreg_d = step_q;
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_BITS'(1);
            end
        end else if (state_q == FIX) begin
            quotient_d  = neg_quot_q ? (-qreg_q) : qreg_q;
            remainder_d = neg_rem_q ? (-rem_mag) : rem_mag;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            a_q         <= '0;
            qreg_q      <= '0;
            vreg_q      <= '0;
            neg_quot_q  <= 1'b0;
            neg_rem_q   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
`ifdef DIV_ZERO_DETECT_EN
            div_zero_q  <= 1'b0;
`endif
        end else begin
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            qreg_q      <= qreg_d;
            vreg_q      <= vreg_d;
            neg_quot_q  <= neg_quot_d;
            neg_rem_q   <= neg_rem_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
`ifdef DIV_ZERO_DETECT_EN
            div_zero_q  <= div_zero_d;
`endif
        end
    end

endmodule

// File: tb/tb_nonrestoring_divider.sv
module tb_nonrestoring_divider;
  import div_pkg::*;

  localparam int N   = 4;
  localparam int AW  = 16;
  localparam int W   = AW + 1 + 2 * N;
  localparam int LAT = N + 2;

  // ---------------------------------------------------------- clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic         start = 1'b0;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         valid;
  logic         busy;
  logic         div_zero;
  div_state_e   dbg_state;

  nonrestoring_divider #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .dividend  (dividend),
    .divisor   (divisor),
    .start     (start),
    .quotient  (quotient),
    .remainder (remainder),
    .valid     (valid),
    .busy      (busy),
    .div_zero  (div_zero),
    .dbg_state (dbg_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ------------------------------------------------------------ scoreboard
  // expected word: {accept cycle, div_zero, quotient, remainder}
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int rst_req = 0;
  int rst_done = 0;
  int tmo_req = 0;
  int tmo_done = 0;

  // Reference: plain integer division (truncating), remainder with dividend sign.
  function automatic logic [W-1:0] model(input logic [N-1:0] dd, input logic [N-1:0] dv,
                                         input int acc);
    int a, b, qi, ri;
    logic [N-1:0] qv, rv;
    logic dz;
    a = $signed(dd);
    b = $signed(dv);
    if (b == 0) begin
`ifdef DIV_ZERO_DETECT_EN
      dz = 1'b1;
      qv = '1;
`else
      dz = 1'b0;
      qi = (a < 0) ? -((1 << N) - 1) : ((1 << N) - 1);
      qv = N'(qi);
`endif
      rv = dd;
    end else begin
      dz = 1'b0;
      qi = a / b;
      ri = a % b;
      qv = N'(qi);
      rv = N'(ri);
    end
    return {AW'(acc), dz, qv, rv};
  endfunction

  // ---------------------------------------------------------------- monitor
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [N-1:0] eq, er;
    logic         edz;
    int           acc, lat, elat;
    if (rst_req != rst_done) begin
      rst_done = rst_req;
      checks++;
      if (quotient !== '0 || remainder !== '0 || valid !== 1'b0 || busy !== 1'b0 ||
          div_zero !== 1'b0 || dbg_state !== IDLE) begin
        errors++;
        $display("FAIL reset_state: q=%0d r=%0d valid=%b busy=%b dz=%b state=%0d, required 0 0 0 0 0 IDLE",
                 quotient, remainder, valid, busy, div_zero, dbg_state);
      end
    end
    if (tmo_req != tmo_done) begin
      tmo_done = tmo_req;
      checks++;
      errors++;
      $display("FAIL timeout: waited too long at cycle %0d, queue depth %0d", cyc, exp_q.size());
    end
    if (valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: valid=1 at cycle %0d, required no pending result", cyc);
      end else begin
        e    = exp_q.pop_front();
        acc  = int'(e[W-1 -: AW]);
        edz  = e[2*N];
        eq   = e[2*N-1 -: N];
        er   = e[N-1:0];
        elat = edz ? 1 : LAT;
        lat  = cyc - acc;
        checks++;
        if (quotient !== eq) begin
          errors++;
          $display("FAIL quotient: got %0d, required %0d", $signed(quotient), $signed(eq));
        end
        checks++;
        if (remainder !== er) begin
          errors++;
          $display("FAIL remainder: got %0d, required %0d", $signed(remainder), $signed(er));
        end
        checks++;
        if (div_zero !== edz) begin
          errors++;
          $display("FAIL div_zero: got %b, required %b", div_zero, edz);
        end
        checks++;
        if (lat != elat) begin
          errors++;
          $display("FAIL latency: got %0d cycles, required %0d", lat, elat);
        end
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL busy_at_valid: got %b, required 0", busy);
        end
        checks++;
        if (prev_valid !== 1'b0) begin
          errors++;
          $display("FAIL valid_pulse: valid high in previous cycle too, required 1-cycle pulse");
        end
      end
    end
    prev_valid = valid;
  end

  // ---------------------------------------------------------------- drivers
  // Returns at a falling edge where the divider can accept a start.
  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (busy) tmo_req++;
  endtask

  task automatic issue(input logic [N-1:0] dd, input logic [N-1:0] dv);
    wait_ready();
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    exp_q.push_back(model(dd, dv, cyc));
    @(negedge clk);
    start    = 1'b0;
    dividend = N'($urandom);
    divisor  = N'($urandom);
  endtask

  int dir_dd[8] = '{7, -7, 7, -3, -8, -8, 5, 0};
  int dir_dv[8] = '{2, 2, -2, -5, -1, 3, 0, 3};

  initial begin
    int n;
    logic [N-1:0] rdd, rdv;

    // reset state
    reset = 1'b1;
    repeat (2) @(negedge clk);
    rst_req++;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // directed cases
    for (int i = 0; i < 8; i++) issue(N'(dir_dd[i]), N'(dir_dv[i]));

    // start while busy is ignored
    wait_ready();
    dividend = N'(6);
    divisor  = N'(4);
    start    = 1'b1;
    exp_q.push_back(model(N'(6), N'(4), cyc));
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    dividend = N'(1);
    divisor  = N'(1);
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    dividend = N'($urandom);
    divisor  = N'($urandom);

    // reset in the middle of an operation
    wait_ready();
    dividend = N'(7);
    divisor  = N'(2);
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    rst_req++;
    @(negedge clk);
    reset = 1'b0;
    issue(N'(5), N'(7));

    // back-to-back with start held through DONE
    wait_ready();
    dividend = N'(-7);
    divisor  = N'(3);
    start    = 1'b1;
    exp_q.push_back(model(N'(-7), N'(3), cyc));
    @(negedge clk);
    dividend = N'(6);
    divisor  = N'(-4);
    n = 0;
    @(negedge clk);
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (busy) tmo_req++;
    exp_q.push_back(model(N'(6), N'(-4), cyc));
    @(negedge clk);
    start = 1'b0;

    // randomized traffic
    for (int i = 0; i < 80; i++) begin
      rdd = N'($urandom_range(0, (1 << N) - 1));
      rdv = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom_range(0, (1 << N) - 1));
      issue(rdd, rdv);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // drain
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) tmo_req++;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
